// File: rtl/vector_mem_strided.sv
// Word-addressed vector scratch memory: strided, masked whole-vector loads and
// stores, EPC elements per beat, with one-cycle completion pulse.
module vector_mem_strided #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int VLEN   = 16,
  parameter int EPC    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [ADDR_W-1:0]        req_stride,
  input  logic [VLEN-1:0]          req_mask,
  input  logic [VLEN*WORD_W-1:0]   req_data,
  output logic                     rsp_valid,
  output logic [VLEN*WORD_W-1:0]   rsp_data
);

  localparam int BEATS  = VLEN / EPC;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (VLEN > 1) ? $clog2(VLEN) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic                     accept;
  logic                     last_beat;

  logic                     write_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [ADDR_W-1:0]        stride_q;
  logic [VLEN-1:0]          mask_q;
  logic [VLEN*WORD_W-1:0]   data_q;

  logic [WORD_W-1:0]        mem_q [DEPTH];
  logic [VLEN*WORD_W-1:0]   rsp_data_q;

  logic [IDX_W-1:0]         lane_idx   [EPC];
  logic [ADDR_W-1:0]        lane_addr  [EPC];
  logic                     lane_en    [EPC];
  logic [WORD_W-1:0]        lane_wdata [EPC];
  logic [WORD_W-1:0]        lane_rdata [EPC];

  // Element address wraps silently modulo DEPTH by truncation to ADDR_W bits.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] stride,
                                                  input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx) * stride;
  endfunction

  assign accept    = (state_q == IDLE) && req_valid;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACCESS;
          beat_d  = '0;
        end
      end
      ACCESS: begin
        if (last_beat) state_d = RESP;
        else           beat_d  = beat_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q  <= req_write;
      addr_q   <= req_addr;
      stride_q <= req_stride;
      mask_q   <= req_mask;
      data_q   <= req_data;
    end
  end

  for (genvar e = 0; e < EPC; e++) begin : g_lane
    assign lane_idx[e]   = IDX_W'(int'(beat_q) * EPC + e);
    assign lane_addr[e]  = elem_addr(addr_q, stride_q, lane_idx[e]);
    assign lane_en[e]    = mask_q[lane_idx[e]];
    assign lane_wdata[e] = data_q[lane_idx[e]*WORD_W +: WORD_W];
    assign lane_rdata[e] = mem_q[lane_addr[e]];
  end

  // Lanes are written in ascending order so the highest aliasing element wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else if ((state_q == ACCESS) && write_q) begin
      for (int e = 0; e < EPC; e++) begin
        if (lane_en[e]) mem_q[lane_addr[e]] <= lane_wdata[e];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data_q <= '0;
    end else if ((state_q == ACCESS) && !write_q) begin
      for (int e = 0; e < EPC; e++) begin
        rsp_data_q[lane_idx[e]*WORD_W +: WORD_W] <= lane_en[e] ? lane_rdata[e] : '0;
      end
    end
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP) && !reset;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/vector_mem_strided.md
Name: vector_mem_strided

Overview:
Parametrised successor to the vector processor's unit-stride vector memory. Word-addressed scratch memory serving whole-vector loads and stores through a valid/ready request port and a one-cycle response pulse. Adds element stride, a per-lane mask, modulo-DEPTH address wrap, and a configurable number of elements per cycle. Sits between the vector register file and the load/store stage.

Parameters:
WORD_W, 32, bits per element/memory word
DEPTH, 512, memory words; must be a power of 2
ADDR_W, 9, log2(DEPTH)
VLEN, 16, elements per vector
EPC, 4, elements accessed per cycle; must divide VLEN; BEATS = VLEN/EPC

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address of element 0
req_stride  in  ADDR_W  unsigned word stride between elements
req_mask  in  VLEN  per-element enable; bit i controls element i
req_data  in  VLEN*WORD_W  store data; element i at [i*WORD_W +: WORD_W]
rsp_valid  out  1  one-cycle completion pulse (loads and stores)
rsp_data  out  VLEN*WORD_W  load result; element i at [i*WORD_W +: WORD_W]

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset:
  - Clears every memory word to 0.
  - State goes to IDLE; rsp_valid=0, rsp_data=0.
  - req_ready=0 while reset is high, 1 on the first cycle after.
  - Reset mid-operation aborts it; no rsp_valid is produced.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. When req_valid is high at an edge, latch write, addr, stride, mask and data; beat counter = 0; go to ACCESS. Request inputs are ignored at all other times.
  - ACCESS: req_ready=0. Beat b handles elements b*EPC .. b*EPC+EPC-1. Advances one beat per cycle; after beat BEATS-1, go to RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly this cycle; next state is IDLE.
- Latency: request accepted at edge 0 → beats at edges 1..BEATS → rsp_valid high in the cycle after edge BEATS. Next accept is possible at edge BEATS+2. Defaults give 4 beats and a 6-cycle request-to-request interval.
- Element address: addr_i = (addr + i*stride) mod DEPTH. Truncate to ADDR_W bits, so wrap-around is silent.
- Store:
  - If mask[i]=1: mem[addr_i] <= data element i. Masked-off words are untouched.
  - Aliasing (stride 0 or wrap collision): the highest element index wins, both within a beat and across beats.
  - rsp_data is unchanged by a store.
- Load:
  - rsp_data element i <= mem[addr_i] if mask[i]=1, else 0.
  - Each element lane is written during its beat.
  - rsp_data is valid from the rsp_valid cycle and held until the next load's beats begin.
- All-zero mask: full BEATS cycles still elapse, rsp_valid is still pulsed. A load returns all zeros; a store writes nothing.
- No response backpressure: the rsp_valid pulse is not repeated.

Test Plan:
- Reset then load addr=0, stride=1, mask=FFFF → rsp_data all zeros; rsp_valid 5 cycles after accept; req_ready low for exactly 5 cycles.
- Store addr=10, stride=1, mask=FFFF, element i = 100+i; then load the same → element i = 100+i; word 26 still 0.
- Store addr=0, stride=3, mask=FFFF, element i = i+1; load addr=0, stride=1 → word 3k = k+1 for k<6; words 1, 2, 4 = 0.
- Wrap: store addr=508, stride=1, element i = 0xA0+i; load addr=0 → elements 0..11 = 0xA4..0xAF; word 508 = 0xA0.
- Mask/alias: store addr=5, stride=0, mask=0x00F0, element i = i → word 5 = 7; then a load with mask=0x0001 → element 0 = 7, others 0.
- Assert reset during beat 2 of a store → no rsp_valid; all memory 0; req_ready=1 one cycle after reset deasserts.
